// File: rtl/particle_dump.sv
// particle_dump: walks every cell's P/V BRAM pair after a timestep and
// streams each live particle out in the same 256-bit format the loader takes.
//
// Output stream handshake: a word transfers on a rising edge where
// data_out_valid and data_out_ready are both high. Once valid is raised,
// data_out and valid are held unchanged until that transfer happens, and
// ready has no effect while valid is low.
module particle_dump #(
  parameter int N_CELL = 27,
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  dump_busy,
  output logic                  done_pulse,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [7:0]            rd_cell,
  input  logic [97*N_CELL-1:0]  p_doutb,
  input  logic [97*N_CELL-1:0]  v_doutb,
  output logic [255:0]          data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic [CNT_W-1:0]      word_count
);

  localparam int PAD_W = 256 - 200 - ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        cell_n;
  logic [255:0]      data_n;
  logic              valid_n;
  logic [CNT_W-1:0]  count_n;
  logic [96:0]       p_sel, v_sel;
  logic              last_cell;

  assign last_cell  = (rd_cell == 8'(N_CELL - 1));
  assign dump_busy  = (state != S_IDLE);
  assign done_pulse = (state == S_DONE);

  // Select the P/V words of the cell currently being read.
  always_comb begin
    p_sel = '0;
    v_sel = '0;
    for (int i = 0; i < N_CELL; i++) begin
      if (rd_cell == 8'(i)) begin
        p_sel = p_doutb[i*97 +: 97];
        v_sel = v_doutb[i*97 +: 97];
      end
    end
  end

  // Next-state and next-datapath decode for the walk.
  always_comb begin
    state_n = state;
    addr_n  = rd_addr;
    cell_n  = rd_cell;
    data_n  = data_out;
    valid_n = data_out_valid;
    count_n = word_count;
    case (state)
      S_IDLE: begin
        if (start) begin
          count_n = '0;
          cell_n  = '0;
          addr_n  = '0;
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Address has been on the BRAM for this cycle; data arrives next.
        state_n = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (p_sel[96]) begin
          // End-of-cell marker: skip it and everything above it.
          if (last_cell) begin
            state_n = S_DONE;
          end else begin
            cell_n  = rd_cell + 8'd1;
            addr_n  = '0;
            state_n = S_ISSUE;
          end
        end else begin
          data_n  = {{PAD_W{1'b0}}, rd_addr, rd_cell, v_sel[95:0], p_sel[95:0]};
          valid_n = 1'b1;
          state_n = S_EMIT;
        end
      end
      S_EMIT: begin
        if (data_out_ready) begin
          valid_n = 1'b0;
          if (word_count != {CNT_W{1'b1}}) count_n = word_count + 1'b1;
          if (rd_addr == {ADDR_W{1'b1}}) begin
            // Cell filled to the top with no marker: no wrap to address 0.
            if (last_cell) begin
              state_n = S_DONE;
            end else begin
              cell_n  = rd_cell + 8'd1;
              addr_n  = '0;
              state_n = S_ISSUE;
            end
          end else begin
            addr_n  = rd_addr + 1'b1;
            state_n = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any dump in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      rd_addr        <= '0;
      rd_cell        <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      word_count     <= '0;
    end else begin
      state          <= state_n;
      rd_addr        <= addr_n;
      rd_cell        <= cell_n;
      data_out       <= data_n;
      data_out_valid <= valid_n;
      word_count     <= count_n;
    end
  end

endmodule

// File: tb/tb_particle_dump.sv
// tb_particle_dump: BRAM model plus a list-based reference of which
// particles a dump must produce, checked word by word on the output stream.
module tb_particle_dump;

  localparam int N_CELL = 27;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                 start;
  logic                 dump_busy, done_pulse;
  logic [ADDR_W-1:0]    rd_addr;
  logic [7:0]           rd_cell;
  logic [97*N_CELL-1:0] p_doutb, v_doutb;
  logic [255:0]         data_out;
  logic                 data_out_valid;
  logic                 data_out_ready;
  logic [CNT_W-1:0]     word_count;

  particle_dump #(.N_CELL(N_CELL), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dump_busy(dump_busy), .done_pulse(done_pulse),
    .rd_addr(rd_addr), .rd_cell(rd_cell),
    .p_doutb(p_doutb), .v_doutb(v_doutb),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .word_count(word_count)
  );

  // ---------------- BRAM model (1-cycle read latency) ----------------
  logic [96:0] p_mem [N_CELL][DEPTH];
  logic [96:0] v_mem [N_CELL][DEPTH];

  always @(posedge clk) begin
    for (int i = 0; i < N_CELL; i++) begin
      p_doutb[i*97 +: 97] <= p_mem[i][rd_addr];
      v_doutb[i*97 +: 97] <= v_mem[i][rd_addr];
    end
  end

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  logic [255:0] exp_q[$];
  int ready_mode = 0;   // 0: always ready, 1: ready 1-in-4, 2: random
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int busy_cycles = 0;
  logic [255:0] last_word = '0;
  logic prev_stall = 1'b0;
  logic [255:0] prev_data = '0;
  int len_arr [N_CELL];

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- driver: ready pattern ----------------
  always @(posedge clk) begin
    #1;
    cyc++;
    case (ready_mode)
      0: data_out_ready = 1'b1;
      1: data_out_ready = (cyc % 4 == 0);
      default: data_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Fill BRAMs: len_arr[c] live particles per cell, marker at that address
  // (len 512 means no marker); garbage above the marker must be skipped.
  task automatic fill_cells();
    for (int c = 0; c < N_CELL; c++) begin
      for (int a = 0; a < DEPTH; a++) begin
        p_mem[c][a] = {1'b0, $urandom(), $urandom(), $urandom()};
        v_mem[c][a] = {1'($urandom_range(0, 1)), $urandom(), $urandom(), $urandom()};
        if (a == len_arr[c]) p_mem[c][a][96] = 1'b1;
        else if (a > len_arr[c]) p_mem[c][a][96] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Reference: list every particle below each cell's first marker, in order.
  task automatic build_exp();
    exp_q.delete();
    for (int c = 0; c < N_CELL; c++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if (p_mem[c][a][96]) break;
        exp_q.push_back({47'b0, 9'(a), 8'(c), v_mem[c][a][95:0], p_mem[c][a][95:0]});
      end
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 256'(data_out_valid), 256'(1));
        chk("stall_data", data_out, prev_data);
      end
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", data_out, 256'(0));
        end else begin
          chk($sformatf("word%0d", acc_cnt), data_out, exp_q.pop_front());
        end
        last_word = data_out;
        acc_cnt++;
      end
      prev_stall = data_out_valid && !data_out_ready;
      prev_data  = data_out;
      if (done_pulse) done_cnt++;
      if (dump_busy) busy_cycles++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", 256'(dump_busy), 256'(1));
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk); #1;
      if (done_pulse) seen = 1;
    end
    if (!seen) chk({name, "_timeout"}, 256'(0), 256'(1));
  endtask

  // Full dump: start, wait for done, check final counters.
  task automatic run_dump(input string name, input int mode, input int exp_busy);
    int n;
    build_exp();
    n = exp_q.size();
    ready_mode = mode;
    acc_cnt = 0; done_cnt = 0; busy_cycles = 0;
    pulse_start();
    wait_done(name);
    repeat (3) @(negedge clk);
    #1;
    chk({name, "_q_empty"}, 256'(exp_q.size()), 256'(0));
    chk({name, "_count"}, 256'(word_count), 256'(n));
    chk({name, "_done_cnt"}, 256'(done_cnt), 256'(1));
    chk({name, "_busy_low"}, 256'(dump_busy), 256'(0));
    if (exp_busy >= 0) chk({name, "_busy_cycles"}, 256'(busy_cycles), 256'(exp_busy));
  endtask

  task automatic set_two_each();
    for (int c = 0; c < N_CELL; c++) len_arr[c] = 2;
    fill_cells();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    start = 1'b0;
    data_out_ready = 1'b1;
    for (int c = 0; c < N_CELL; c++) len_arr[c] = 0;
    fill_cells();
    repeat (3) @(negedge clk);
    chk("rst_valid", 256'(data_out_valid), 256'(0));
    chk("rst_busy", 256'(dump_busy), 256'(0));
    chk("rst_done", 256'(done_pulse), 256'(0));
    chk("rst_count", 256'(word_count), 256'(0));
    chk("rst_addr", 256'(rd_addr), 256'(0));
    chk("rst_cell", 256'(rd_cell), 256'(0));
    chk("rst_data", data_out, 256'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Test 1: two particles per cell, ready high.
    set_two_each();
    build_exp();
    chk("t1_model_size", 256'(exp_q.size()), 256'(54));
    chk("t1_model_first", exp_q[0],
        {47'b0, 9'd0, 8'd0, v_mem[0][0][95:0], p_mem[0][0][95:0]});
    run_dump("t1", 0, 217);

    // Test 2: single particle in cell 5.
    for (int c = 0; c < N_CELL; c++) len_arr[c] = 0;
    len_arr[5] = 1;
    fill_cells();
    p_mem[5][0] = 97'h123;
    v_mem[5][0] = 97'h456;
    run_dump("t2", 0, 27 * 2 + 3 + 1);
    chk("t2_word", last_word,
        {47'b0, 9'd0, 8'd5, 96'h456, 96'h123});

    // Test 3: same data as test 1 with ready 1-in-4.
    set_two_each();
    run_dump("t3", 1, -1);

    // Test 4: cell 26 full, no marker.
    for (int c = 0; c < N_CELL; c++) len_arr[c] = 0;
    len_arr[26] = DEPTH;
    fill_cells();
    run_dump("t4", 0, 26 * 2 + 512 * 3 + 1);
    chk("t4_last_addr", 256'(last_word[208:200]), 256'(511));
    chk("t4_last_cell", 256'(last_word[199:192]), 256'(26));

    // Test 5: reset mid-EMIT at word 10, then a clean dump.
    set_two_each();
    build_exp();
    ready_mode = 1;
    acc_cnt = 0; done_cnt = 0;
    pulse_start();
    begin
      bit hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
        @(negedge clk); #1;
        if (acc_cnt == 10 && data_out_valid) hit = 1;
      end
      if (!hit) chk("t5_reach_word10", 256'(0), 256'(1));
    end
    reset = 1'b1;
    #1;
    chk("t5_valid", 256'(data_out_valid), 256'(0));
    chk("t5_busy", 256'(dump_busy), 256'(0));
    chk("t5_count", 256'(word_count), 256'(0));
    @(negedge clk); #1;
    chk("t5_done_none", 256'(done_pulse), 256'(0));
    chk("t5_count_held", 256'(word_count), 256'(0));
    chk("t5_data", data_out, 256'(0));
    reset = 1'b0;
    chk("t5_done_cnt", 256'(done_cnt), 256'(0));
    run_dump("t5b", 2, -1);

    // Test 6: start while busy and coincident with done_pulse are ignored.
    set_two_each();
    build_exp();
    ready_mode = 0;
    acc_cnt = 0; done_cnt = 0; busy_cycles = 0;
    pulse_start();
    begin
      bit hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
        @(negedge clk); #1;
        if (acc_cnt == 5) hit = 1;
      end
      if (!hit) chk("t6_reach_word5", 256'(0), 256'(1));
    end
    start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    wait_done("t6");
    start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("t6_busy_low", 256'(dump_busy), 256'(0));
    chk("t6_done_cnt", 256'(done_cnt), 256'(1));
    chk("t6_busy_cycles", 256'(busy_cycles), 256'(217));
    chk("t6_count", 256'(word_count), 256'(54));
    chk("t6_q_empty", 256'(exp_q.size()), 256'(0));

    // Test 7: random cell occupancy with random backpressure.
    for (int c = 0; c < N_CELL; c++) len_arr[c] = $urandom_range(0, 6);
    len_arr[$urandom_range(0, N_CELL - 1)] = $urandom_range(20, 40);
    fill_cells();
    run_dump("t7", 2, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
